mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 48 ++++
 rtl/mem_wb_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the MEM/WB stage, the EX/MEM pipeline side, the data memory and WB.
// "slave" is the stage itself; "master" is everything around it.
interface mem_wb_stage_if #(
  parameter int DATA_W = 19,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              reg_write_m;
  logic              result_src_m;
  logic              mem_read_m;
  logic              mem_write_m;
  logic              byte_m;
  logic              sign_ext_m;
  logic [RD_W-1:0]   rd_m;
  logic [DATA_W-1:0] alu_result_m;
  logic [DATA_W-1:0] write_data_m;
  logic              flush;
  logic              stall_m;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_byte;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              valid_w;
  logic              reg_write_w;
  logic              result_src_w;
  logic              mem_err_w;
  logic [RD_W-1:0]   rd_w;
  logic [DATA_W-1:0] alu_result_w;
  logic [DATA_W-1:0] read_data_w;
  logic [DATA_W-1:0] result_w;

  modport slave (
    input  in_valid, reg_write_m, result_src_m, mem_read_m, mem_write_m, byte_m, sign_ext_m,
           rd_m, alu_result_m, write_data_m, flush, dmem_ack, dmem_rdata,
    output stall_m, dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
           valid_w, reg_write_w, result_src_w, mem_err_w, rd_w, alu_result_w, read_data_w, result_w
  );

  modport master (
    output in_valid, reg_write_m, result_src_m, mem_read_m, mem_write_m, byte_m, sign_ext_m,
           rd_m, alu_result_m, write_data_m, flush, dmem_ack, dmem_rdata,
    input  stall_m, dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
           valid_w, reg_write_w, result_src_w, mem_err_w, rd_w, alu_result_w, read_data_w, result_w
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: non-memory ops retire in one cycle, loads/stores hold the pipe
// while a single data-memory request is outstanding, bounded by a timeout.
module mem_wb_stage #(
  parameter int DATA_W  = 19,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d, kill_s;
  logic              rq_reg_write_q, rq_reg_write_d;
  logic              rq_result_src_q, rq_result_src_d;
  logic              rq_mem_write_q, rq_mem_write_d;
  logic              rq_byte_q, rq_byte_d;
  logic              rq_sign_ext_q, rq_sign_ext_d;
  logic [RD_W-1:0]   rq_rd_q, rq_rd_d;
  logic [DATA_W-1:0] rq_addr_q, rq_addr_d;
  logic [DATA_W-1:0] rq_wdata_q, rq_wdata_d;
  logic              valid_w_q, valid_w_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic              result_src_w_q, result_src_w_d;
  logic              mem_err_w_q, mem_err_w_d;
  logic [RD_W-1:0]   rd_w_q, rd_w_d;
  logic [DATA_W-1:0] alu_result_w_q, alu_result_w_d;
  logic [DATA_W-1:0] read_data_w_q, read_data_w_d;
  logic              access_s;
  logic [DATA_W-1:0] wdata_s;

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                 input logic is_byte, input logic sx);
    logic [DATA_W-1:0] r;
    if (!is_byte) begin
      r = raw;
    end else begin
      r = (sx && raw[7]) ? '1 : '0;
      r[7:0] = raw[7:0];
    end
    return r;
  endfunction

  // Next-state, request latch and WB register update.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    kill_d          = kill_q;
    kill_s          = kill_q | bus.flush;
    rq_reg_write_d  = rq_reg_write_q;
    rq_result_src_d = rq_result_src_q;
    rq_mem_write_d  = rq_mem_write_q;
    rq_byte_d       = rq_byte_q;
    rq_sign_ext_d   = rq_sign_ext_q;
    rq_rd_d         = rq_rd_q;
    rq_addr_d       = rq_addr_q;
    rq_wdata_d      = rq_wdata_q;
    valid_w_d       = 1'b0;
    reg_write_w_d   = 1'b0;
    mem_err_w_d     = 1'b0;
    result_src_w_d  = result_src_w_q;
    rd_w_d          = rd_w_q;
    alu_result_w_d  = alu_result_w_q;
    read_data_w_d   = read_data_w_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          if (bus.mem_read_m || bus.mem_write_m) begin
            state_d         = S_ACCESS;
            cnt_d           = '0;
            kill_d          = 1'b0;
            rq_reg_write_d  = bus.reg_write_m;
            rq_result_src_d = bus.result_src_m;
            rq_mem_write_d  = bus.mem_write_m;
            rq_byte_d       = bus.byte_m;
            rq_sign_ext_d   = bus.sign_ext_m;
            rq_rd_d         = bus.rd_m;
            rq_addr_d       = bus.alu_result_m;
            rq_wdata_d      = bus.write_data_m;
          end else begin
            valid_w_d      = 1'b1;
            reg_write_w_d  = bus.reg_write_m;
            result_src_w_d = bus.result_src_m;
            rd_w_d         = bus.rd_m;
            alu_result_w_d = bus.alu_result_m;
            read_data_w_d  = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (bus.dmem_ack) begin
          state_d        = S_IDLE;
          kill_d         = 1'b0;
          valid_w_d      = !kill_s;
          reg_write_w_d  = rq_reg_write_q & !kill_s;
          result_src_w_d = rq_result_src_q;
          rd_w_d         = rq_rd_q;
          alu_result_w_d = rq_addr_q;
          read_data_w_d  = rq_mem_write_q ? '0 : load_ext(bus.dmem_rdata, rq_byte_q, rq_sign_ext_q);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d        = S_IDLE;
          cnt_d          = cnt_q + CNT_W'(1);
          kill_d         = 1'b0;
          valid_w_d      = !kill_s;
          mem_err_w_d    = !kill_s;
          result_src_w_d = rq_result_src_q;
          rd_w_d         = rq_rd_q;
          alu_result_w_d = rq_addr_q;
          read_data_w_d  = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          kill_d = kill_s;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and WB registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      kill_q          <= 1'b0;
      rq_reg_write_q  <= 1'b0;
      rq_result_src_q <= 1'b0;
      rq_mem_write_q  <= 1'b0;
      rq_byte_q       <= 1'b0;
      rq_sign_ext_q   <= 1'b0;
      rq_rd_q         <= '0;
      rq_addr_q       <= '0;
      rq_wdata_q      <= '0;
      valid_w_q       <= 1'b0;
      reg_write_w_q   <= 1'b0;
      result_src_w_q  <= 1'b0;
      mem_err_w_q     <= 1'b0;
      rd_w_q          <= '0;
      alu_result_w_q  <= '0;
      read_data_w_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      kill_q          <= kill_d;
      rq_reg_write_q  <= rq_reg_write_d;
      rq_result_src_q <= rq_result_src_d;
      rq_mem_write_q  <= rq_mem_write_d;
      rq_byte_q       <= rq_byte_d;
      rq_sign_ext_q   <= rq_sign_ext_d;
      rq_rd_q         <= rq_rd_d;
      rq_addr_q       <= rq_addr_d;
      rq_wdata_q      <= rq_wdata_d;
      valid_w_q       <= valid_w_d;
      reg_write_w_q   <= reg_write_w_d;
      result_src_w_q  <= result_src_w_d;
      mem_err_w_q     <= mem_err_w_d;
      rd_w_q          <= rd_w_d;
      alu_result_w_q  <= alu_result_w_d;
      read_data_w_q   <= read_data_w_d;
    end
  end

  // Byte stores only carry the low byte on the bus.
  always_comb begin
    wdata_s = rq_wdata_q;
    if (rq_byte_q) begin
      wdata_s      = '0;
      wdata_s[7:0] = rq_wdata_q[7:0];
    end else begin
      wdata_s = rq_wdata_q;
    end
  end

  assign access_s       = (state_q == S_ACCESS);
  assign bus.stall_m    = access_s;
  assign bus.dmem_req   = access_s;
  assign bus.dmem_we    = access_s & rq_mem_write_q;
  assign bus.dmem_byte  = access_s & rq_byte_q;
  assign bus.dmem_addr  = access_s ? rq_addr_q : '0;
  assign bus.dmem_wdata = access_s ? wdata_s : '0;

  assign bus.valid_w      = valid_w_q;
  assign bus.reg_write_w  = reg_write_w_q;
  assign bus.result_src_w = result_src_w_q;
  assign bus.mem_err_w    = mem_err_w_q;
  assign bus.rd_w         = rd_w_q;
  assign bus.alu_result_w = alu_result_w_q;
  assign bus.read_data_w  = read_data_w_q;
  assign bus.result_w     = result_src_w_q ? read_data_w_q : alu_result_w_q;
endmodule
